bp_update_queue: RTL
====================

Name: bp_update_queue

Overview:
- Write-side companion to the bimodal BHT.
- Records each prediction made at fetch in an in-order queue tagged with BHT index, predicted direction/target and domain.
- Matches branch resolutions from execute against the oldest entry and produces the registered BHT update stream (result, update enable, index, target, domain).
- Detects mispredictions, squashes younger wrong-path entries and keeps per-domain saturating mispredict counters.

Parameters:
- DEPTH, 8, queue entries; power of two, >=2.
- IDX_W, `BHT_IDX_WIDTH, BHT index width.
- CNT_W, 16, width of each mispredict counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: synchronous, active-low.
- pred_valid_i  in  1  enqueue request for a new prediction.
- pred_ready_o  out  1  queue not full.
- pred_idx_i  in  IDX_W  BHT index of the prediction.
- pred_taken_i  in  1  predicted direction.
- pred_targ_i  in  32  predicted target.
- pred_domain_i  in  domain_t  owner domain (PRIV/USER).
- res_valid_i  in  1  resolution for the oldest branch.
- res_ready_o  out  1  queue not empty.
- res_taken_i  in  1  actual direction.
- res_targ_i  in  32  actual target.
- flush_i  in  1  external squash of all entries (exception or domain switch).
- upd_en_o  out  1  update strobe to BHT.
- upd_result_o  out  1  actual direction.
- upd_idx_o  out  IDX_W  index to update.
- upd_targ_o  out  32  actual target.
- upd_domain_o  out  domain_t  domain of the updated entry.
- mispredict_o  out  1  resolved branch was mispredicted; redirect fetch.
- redirect_targ_o  out  32  correct next fetch target.
- cnt_priv_o  out  CNT_W  PRIV mispredict count.
- cnt_user_o  out  CNT_W  USER mispredict count.

Behaviour:
- Reset (rst_i=0 at posedge) clears the queue: wr/rd pointers 0, count 0.
  - Outputs after reset: pred_ready_o=1, res_ready_o=0.
  - upd_en_o, mispredict_o, upd_result_o = 0.
  - upd_idx_o, upd_targ_o, redirect_targ_o, counters = 0.
  - upd_domain_o=INIT.
  - Reset mid-operation discards all entries with no update emitted.
- Storage: circular buffer, DEPTH entries of {idx, taken, targ, domain}. Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Ready signals are combinational from count, with no same-cycle bypass:
  - pred_ready_o = (count != DEPTH).
  - res_ready_o = (count != 0).
- Enqueue fires on pred_valid_i & pred_ready_o. Resolve fires on res_valid_i & res_ready_o and always consumes the head entry.
- Mispredict condition for the head entry: (res_taken_i != head.taken), or (res_taken_i & head.taken & res_targ_i != head.targ).
- Outputs are registered; latency is 1 cycle after the resolve fire. On the resolve cycle the next-edge values are:
  - upd_en_o=1, upd_result_o=res_taken_i, upd_idx_o=head.idx, upd_domain_o=head.domain.
  - upd_targ_o = res_targ_i if taken, else head.targ.
  - mispredict_o = mispredict condition.
  - redirect_targ_o = res_targ_i if taken, else 0.
- In any cycle without a resolve fire: upd_en_o=0 and mispredict_o=0. Data outputs hold their last values.
- Mispredict on the resolve cycle:
  - Head is popped and all younger entries are squashed; queue becomes empty at the edge.
  - A same-cycle enqueue is dropped (wrong path).
  - The counter for head.domain increments, saturating at 2^CNT_W-1. Head domain INIT increments neither counter.
- flush_i=1:
  - Queue becomes empty at the edge; a same-cycle enqueue is dropped.
  - A same-cycle resolve is still applied: its update, mispredict_o and counter are emitted, then the queue empties.
- Simultaneous enqueue and resolve without mispredict or flush: count is unchanged and both pointers advance.
- Full queue plus resolve: enqueue is not accepted that cycle, because pred_ready_o is evaluated before the pop.
- Resolve while empty: ignored. No update, no state change.
- Counters are never cleared except by reset.

Test Plan:
- Reset then enqueue idx=5, taken=1, targ=0x100, PRIV; resolve taken=1, targ=0x100 -> next cycle upd_en_o=1, upd_idx_o=5, upd_result_o=1, upd_targ_o=0x100, upd_domain_o=PRIV, mispredict_o=0, cnt_priv_o=0.
- Fill 8 entries -> pred_ready_o=0; a 9th pred_valid_i is not accepted. Resolve plus enqueue in the same cycle -> count stays 7; idx values return in FIFO order across pointer wrap.
- Enqueue idx 1,2,3 (USER, predicted not-taken); resolve head taken=1, targ=0x2000 -> mispredict_o=1, redirect_targ_o=0x2000, upd_idx_o=1, cnt_user_o=1, res_ready_o=0 next cycle. A same-cycle enqueue is absent from the queue.
- Target mismatch: predicted taken targ=0x40, actual taken targ=0x80 -> mispredict_o=1, upd_targ_o=0x80, upd_domain_o=PRIV.
- Enqueue 3 entries, assert flush_i together with a correct resolve -> one update emitted (upd_en_o=1, mispredict_o=0), queue empty afterwards. Reset asserted with 4 entries queued -> all outputs at their reset values, counters 0.
- Force 65536 PRIV mispredicts -> cnt_priv_o saturates at 0xFFFF; cnt_user_o unchanged.

Source files
------------

// File: rtl/bp_update_queue.sv
// In-order queue of fetch-time branch predictions, matched against execute-stage
// resolutions to produce the registered BHT update stream and mispredict stats.
`ifndef BHT_IDX_WIDTH
`define BHT_IDX_WIDTH 6
`endif

package bp_pkg;
  typedef enum logic [1:0] {
    INIT = 2'd0,
    PRIV = 2'd1,
    USER = 2'd2
  } domain_t;
endpackage

module bp_update_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = `BHT_IDX_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pred_valid_i,
  output logic              pred_ready_o,
  input  logic [IDX_W-1:0]  pred_idx_i,
  input  logic              pred_taken_i,
  input  logic [31:0]       pred_targ_i,
  input  domain_t           pred_domain_i,
  input  logic              res_valid_i,
  output logic              res_ready_o,
  input  logic              res_taken_i,
  input  logic [31:0]       res_targ_i,
  input  logic              flush_i,
  output logic              upd_en_o,
  output logic              upd_result_o,
  output logic [IDX_W-1:0]  upd_idx_o,
  output logic [31:0]       upd_targ_o,
  output domain_t           upd_domain_o,
  output logic              mispredict_o,
  output logic [31:0]       redirect_targ_o,
  output logic [CNT_W-1:0]  cnt_priv_o,
  output logic [CNT_W-1:0]  cnt_user_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;

  logic [IDX_W-1:0] mem_idx   [DEPTH];
  logic             mem_taken [DEPTH];
  logic [31:0]      mem_targ  [DEPTH];
  domain_t          mem_dom   [DEPTH];

  logic             upd_en_reg, upd_en_next;
  logic             upd_result_reg, upd_result_next;
  logic [IDX_W-1:0] upd_idx_reg, upd_idx_next;
  logic [31:0]      upd_targ_reg, upd_targ_next;
  domain_t          upd_domain_reg, upd_domain_next;
  logic             mispredict_reg, mispredict_next;
  logic [31:0]      redirect_reg, redirect_next;

  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic [31:0]      head_targ;
  domain_t          head_dom;

  logic enq_fire, res_fire, mispred, squash, enq_accept;

  assign pred_ready_o = (count_reg != FULL);
  assign res_ready_o  = (count_reg != '0);

  // The head must be visible in the resolve cycle, so the small buffer is read asynchronously.
  assign head_idx   = mem_idx[rd_ptr_reg];
  assign head_taken = mem_taken[rd_ptr_reg];
  assign head_targ  = mem_targ[rd_ptr_reg];
  assign head_dom   = mem_dom[rd_ptr_reg];

  assign enq_fire   = pred_valid_i & pred_ready_o;
  assign res_fire   = res_valid_i & res_ready_o;
  assign mispred    = res_fire & ((res_taken_i != head_taken) |
                                  (res_taken_i & head_taken & (res_targ_i != head_targ)));
  assign squash     = mispred | flush_i;
  assign enq_accept = enq_fire & ~squash;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (squash) begin
      // Emptying by catching the read pointer up keeps the write pointer untouched.
      rd_ptr_next = wr_ptr_reg;
      count_next  = '0;
    end else begin
      if (enq_accept) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (res_fire)   rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({enq_accept, res_fire})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_comb begin
    upd_en_next     = res_fire;
    mispredict_next = mispred;
    upd_result_next = upd_result_reg;
    upd_idx_next    = upd_idx_reg;
    upd_targ_next   = upd_targ_reg;
    upd_domain_next = upd_domain_reg;
    redirect_next   = redirect_reg;
    if (res_fire) begin
      upd_result_next = res_taken_i;
      upd_idx_next    = head_idx;
      upd_domain_next = head_dom;
      upd_targ_next   = res_taken_i ? res_targ_i : head_targ;
      redirect_next   = res_taken_i ? res_targ_i : 32'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_accept) begin
      mem_idx[wr_ptr_reg]   <= pred_idx_i;
      mem_taken[wr_ptr_reg] <= pred_taken_i;
      mem_targ[wr_ptr_reg]  <= pred_targ_i;
      mem_dom[wr_ptr_reg]   <= pred_domain_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      upd_en_reg     <= 1'b0;
      upd_result_reg <= 1'b0;
      upd_idx_reg    <= '0;
      upd_targ_reg   <= '0;
      upd_domain_reg <= INIT;
      mispredict_reg <= 1'b0;
      redirect_reg   <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      upd_en_reg     <= upd_en_next;
      upd_result_reg <= upd_result_next;
      upd_idx_reg    <= upd_idx_next;
      upd_targ_reg   <= upd_targ_next;
      upd_domain_reg <= upd_domain_next;
      mispredict_reg <= mispredict_next;
      redirect_reg   <= redirect_next;
    end
  end

  // One saturating counter per tracked domain; INIT-owned entries match neither.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    localparam domain_t DOM = (gi == 0) ? PRIV : USER;
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        cnt_reg <= '0;
      end else if (mispred && (head_dom == DOM) && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign cnt_priv_o      = g_cnt[0].cnt_reg;
  assign cnt_user_o      = g_cnt[1].cnt_reg;
  assign upd_en_o        = upd_en_reg;
  assign upd_result_o    = upd_result_reg;
  assign upd_idx_o       = upd_idx_reg;
  assign upd_targ_o      = upd_targ_reg;
  assign upd_domain_o    = upd_domain_reg;
  assign mispredict_o    = mispredict_reg;
  assign redirect_targ_o = redirect_reg;

endmodule
